// File: rtl/rr_pkg.sv
// Shared constants and types for the round-robin requester front end.
// Optional protocol checking is selected by the RR_REQ_CHECK_EN macro in rr_requester.
package rr_pkg;

  localparam int RR_N        = 4;  // default number of clients
  localparam int RR_TS_WIDTH = 4;  // default job-length field width
  localparam int RR_DEPTH    = 4;  // default per-client queue depth

  // Client-index width for the default configuration.
  localparam int RR_CIDX_W = $clog2(RR_N);

  // Job length in beats; zero is illegal and never enters a queue.
  typedef logic [RR_TS_WIDTH-1:0] job_len_t;

endpackage

// File: rtl/rr_req_fifo.sv
// Single-client queue of job lengths. A push is taken only when the queue is
// not full, even if a pop happens on the same edge; a pop is taken only when
// the queue is not empty. Simultaneous push and pop leave the count unchanged.
module rr_req_fifo
  import rr_pkg::*;
#(
  parameter int W     = RR_TS_WIDTH,
  parameter int DEPTH = RR_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage array: written on accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rr_requester.sv
// Requester-side front end for a round-robin arbiter: per-client job-length
// queues raise req while non-empty, each granted cycle issues one registered
// beat tagged with the client index, and the head job pops on its last beat.
// Optional macro RR_REQ_CHECK_EN enables the sticky protocol error flag.
//
// Handshakes: a job transfers on an edge where job_valid[i] && job_ready[i];
// a beat is consumed on an edge where grant[i] && req[i]. req never depends
// on grant, and job_ready never depends on job_valid, so there are no
// combinational loops through the arbiter or the job sources.
module rr_requester
  import rr_pkg::*;
#(
  parameter int N        = RR_N,
  parameter int ts_width = RR_TS_WIDTH,
  parameter int DEPTH    = RR_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            job_valid,
  input  logic [N*ts_width-1:0]   job_len,
  output logic [N-1:0]            job_ready,
  output logic [N-1:0]            req,
  input  logic [N-1:0]            grant,
  output logic                    beat_valid,
  output logic [$clog2(N)-1:0]    beat_client,
  output logic                    beat_last,
  output logic                    err
);

  localparam int CW = $clog2(N);

  logic [N-1:0]        w_full;
  logic [N-1:0]        w_empty;
  logic [N-1:0]        w_push;
  logic [N-1:0]        w_pop;
  logic [N-1:0]        w_gr;
  logic [ts_width-1:0] w_head [N];
  logic [ts_width-1:0] r_done [N];

  logic                w_sel_valid;
  logic [CW-1:0]       w_sel;
  logic                w_sel_last;

  logic                r_beat_valid;
  logic [CW-1:0]       r_beat_client;
  logic                r_beat_last;

  assign job_ready = ~w_full;
  assign req       = ~w_empty;
  assign w_gr      = grant & req;

  for (genvar g = 0; g < N; g++) begin : g_client
    // Zero-length jobs are dropped at the door so they never issue beats.
    assign w_push[g] = job_valid[g] && !w_full[g] &&
                       (job_len[g*ts_width +: ts_width] != '0);
    assign w_pop[g]  = w_sel_valid && (w_sel == CW'(g)) && w_sel_last;

    rr_req_fifo #(
      .W     (ts_width),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[g]),
      .i_data  (job_len[g*ts_width +: ts_width]),
      .i_pop   (w_pop[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_head  (w_head[g])
    );
  end

  // Serve the lowest-index client that is both granted and requesting.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_gr[i]) begin
        w_sel_valid = 1'b1;
        w_sel       = CW'(i);
      end
    end
    w_sel_last = ((r_done[w_sel] + 1'b1) == w_head[w_sel]);
  end

  // Head beat counters: advance on each served beat, clear on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_done[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_sel_valid && (w_sel == CW'(i))) begin
          r_done[i] <= w_sel_last ? '0 : r_done[i] + 1'b1;
        end
      end
    end
  end

  // Registered beat stream, one cycle after the grant is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_valid  <= 1'b0;
      r_beat_client <= '0;
      r_beat_last   <= 1'b0;
    end else begin
      r_beat_valid  <= w_sel_valid;
      r_beat_client <= w_sel;
      r_beat_last   <= w_sel_valid && w_sel_last;
    end
  end

  assign beat_valid  = r_beat_valid;
  assign beat_client = r_beat_client;
  assign beat_last   = r_beat_last;

`ifdef RR_REQ_CHECK_EN
  logic [N-1:0] w_zero_len;
  logic         w_err_event;
  logic         r_err;

  for (genvar g = 0; g < N; g++) begin : g_zero
    assign w_zero_len[g] = (job_len[g*ts_width +: ts_width] == '0);
  end

  // Multi-hot grant, grant to an idle client, or an accepted zero-length push.
  assign w_err_event = (|(grant & (grant - 1'b1))) ||
                       (|(grant & ~req)) ||
                       (|(job_valid & ~w_full & w_zero_len));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= r_err || w_err_event;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
